// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle CPU control: opcodes, functs,
// FSM states, datapath mux encodings and the decoded instruction class.
package mc_pkg;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ALU_LAST = 6'd7;
    localparam logic [5:0] FN_JPR      = 6'd25;
    localparam logic [5:0] FN_JRL      = 6'd26;
    localparam logic [5:0] FN_WWD      = 6'd28;
    localparam logic [5:0] FN_HLT      = 6'd29;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] REG_DST_RT   = 2'd0;
    localparam logic [1:0] REG_DST_RD   = 2'd1;
    localparam logic [1:0] REG_DST_LINK = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MDR = 2'd1;
    localparam logic [1:0] WB_SEL_PC1 = 2'd2;

    typedef enum logic [3:0] {
        CL_R_ALU,
        CL_I_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_JUMP_REG,
        CL_LINK,
        CL_LINK_REG,
        CL_WWD,
        CL_HALT,
        CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier; shared with the pipelined control.
module mc_decode
    import mc_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] instr,
    output iclass_t              iclass,
    output logic                 ext_zero
);

    logic [3:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[WORD_SIZE-1 -: 4];
    assign funct         = instr[5:0];
    // Register fields are consumed by the datapath, not by the classifier.
    assign unused_fields = ^instr[WORD_SIZE-5:6];
    assign ext_zero      = (opcode == OP_ORI);

    // Map opcode/funct to an instruction class; anything unlisted is illegal.
    always_comb begin
        iclass = CL_ILLEGAL;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: iclass = CL_BRANCH;
            OP_ADI, OP_ORI, OP_LHI:         iclass = CL_I_ALU;
            OP_LWD:                         iclass = CL_LOAD;
            OP_SWD:                         iclass = CL_STORE;
            OP_JMP:                         iclass = CL_JUMP;
            OP_JAL:                         iclass = CL_LINK;
            OP_RTYPE: begin
                if (funct <= FN_ALU_LAST) begin
                    iclass = CL_R_ALU;
                end else begin
                    case (funct)
                        FN_JPR:  iclass = CL_JUMP_REG;
                        FN_JRL:  iclass = CL_LINK_REG;
                        FN_WWD:  iclass = CL_WWD;
                        FN_HLT:  iclass = CL_HALT;
                        default: iclass = CL_ILLEGAL;
                    endcase
                end
            end
            default: iclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences IF/ID/EX/MEM/WB per instruction class,
// handles variable-latency memory with a wait timeout, counts instructions.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RST  | post-reset idle, all strobes low, advances to IF
// ST_IF   | fetch from PC, wait for mem_ready, load IR
// ST_ID   | decode; jumps/illegal finish here, links go straight to WB
// ST_EX   | ALU operand select; branches and WWD finish here
// ST_MEM  | data access at ALUOut, wait for mem_ready; SWD finishes here
// ST_WB   | register write-back and PC update
// ST_HALT | stopped (HLT or memory timeout), left only through reset
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 bcond,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_b,
    output logic                 ext_zero,
    output logic                 out_write,
    output logic [CNT_W-1:0]     num_inst,
    output logic                 is_halted,
    output logic                 bus_error,
    output logic                 illegal
);

    // The wait counter only needs to reach MEM_TIMEOUT-1: the cycle that
    // would make it MEM_TIMEOUT is the one that triggers the halt.
    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state, state_nxt;
    iclass_t             iclass;
    logic                dec_ext_zero;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                wait_expired;
    logic                count_inst;
    logic                set_illegal;
    logic                set_bus_error;

    mc_decode #(
        .WORD_SIZE (WORD_SIZE)
    ) u_decode (
        .instr    (instr),
        .iclass   (iclass),
        .ext_zero (dec_ext_zero)
    );

    assign wait_expired = TIMEOUT_EN && (wait_cnt == TO_LAST);

    // Next-state and datapath strobes from state, decoded class, bcond and mem_ready.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = '0;
        count_inst    = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_SEQ;
        reg_write     = 1'b0;
        reg_dst       = REG_DST_RT;
        wb_sel        = WB_SEL_ALU;
        alu_src_b     = 1'b0;
        ext_zero      = 1'b0;
        out_write     = 1'b0;
        is_halted     = 1'b0;
        case (state)
            ST_RST: state_nxt = ST_IF;
            ST_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = ST_ID;
                end else if (wait_expired) begin
                    set_bus_error = 1'b1;
                    state_nxt     = ST_HALT;
                end else if (TIMEOUT_EN) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ID: begin
                case (iclass)
                    CL_JUMP: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_JUMP;
                        count_inst = 1'b1;
                        state_nxt  = ST_IF;
                    end
                    CL_JUMP_REG: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_REG;
                        count_inst = 1'b1;
                        state_nxt  = ST_IF;
                    end
                    CL_LINK, CL_LINK_REG: state_nxt = ST_WB;
                    CL_HALT: begin
                        count_inst = 1'b1;
                        state_nxt  = ST_HALT;
                    end
                    CL_ILLEGAL: begin
                        pc_write    = 1'b1;
                        set_illegal = 1'b1;
                        count_inst  = 1'b1;
                        state_nxt   = ST_IF;
                    end
                    default: state_nxt = ST_EX;
                endcase
            end
            ST_EX: begin
                case (iclass)
                    CL_R_ALU: state_nxt = ST_WB;
                    CL_I_ALU: begin
                        alu_src_b = 1'b1;
                        ext_zero  = dec_ext_zero;
                        state_nxt = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    CL_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_src     = bcond ? PC_SRC_BRANCH : PC_SRC_SEQ;
                        count_inst = 1'b1;
                        state_nxt  = ST_IF;
                    end
                    CL_WWD: begin
                        out_write  = 1'b1;
                        pc_write   = 1'b1;
                        count_inst = 1'b1;
                        state_nxt  = ST_IF;
                    end
                    default: state_nxt = ST_IF;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (iclass == CL_STORE);
                if (mem_ready) begin
                    if (iclass == CL_STORE) begin
                        pc_write   = 1'b1;
                        count_inst = 1'b1;
                        state_nxt  = ST_IF;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (wait_expired) begin
                    set_bus_error = 1'b1;
                    state_nxt     = ST_HALT;
                end else if (TIMEOUT_EN) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                count_inst = 1'b1;
                state_nxt  = ST_IF;
                case (iclass)
                    CL_R_ALU: reg_dst = REG_DST_RD;
                    CL_LOAD:  wb_sel  = WB_SEL_MDR;
                    CL_LINK: begin
                        reg_dst = REG_DST_LINK;
                        wb_sel  = WB_SEL_PC1;
                        pc_src  = PC_SRC_JUMP;
                    end
                    CL_LINK_REG: begin
                        reg_dst = REG_DST_LINK;
                        wb_sel  = WB_SEL_PC1;
                        pc_src  = PC_SRC_REG;
                    end
                    default: reg_dst = REG_DST_RT;
                endcase
            end
            ST_HALT: is_halted = 1'b1;
            default: state_nxt = ST_RST;
        endcase
    end

    // State, wait counter, instruction counter and sticky error flags.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state     <= ST_RST;
            wait_cnt  <= '0;
            num_inst  <= '0;
            bus_error <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (count_inst) begin
                num_inst <= num_inst + CNT_W'(1);
            end
            if (set_bus_error) begin
                bus_error <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multi-cycle control unit for the 16-bit accumulator-free 4-register CPU.
- Drives the datapath through the IF/ID/EX/MEM/WB sequence per instruction class.
- Adds a variable-latency memory handshake, a wait timeout, an instruction counter, halt handling and illegal-opcode detection.
- Sits between the instruction register and the datapath/memory port, inside cpu.

Parameters:
- WORD_SIZE, 16, instruction/data word width; opcode = instr[WORD_SIZE-1 -: 4], funct = instr[5:0].
- CNT_W, 16, width of the num_inst counter.
- MEM_TIMEOUT, 15, maximum consecutive cycles waiting for mem_ready before bus error; 0 disables the timeout.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- instr  in  WORD_SIZE  current instruction register contents.
- bcond  in  1  branch condition from the ALU, valid in EX.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req.
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  out  1  load the IR from memory data.
- pc_write  out  1  update the PC this cycle.
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 = rs.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r2 (link register).
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC+1.
- alu_src_b  out  1  0 = rt, 1 = extended immediate.
- ext_zero  out  1  1 = zero-extend (ORI), 0 = sign-extend.
- out_write  out  1  latch rs into output_port (WWD).
- num_inst  out  CNT_W  count of completed instructions.
- is_halted  out  1  CPU halted.
- bus_error  out  1  sticky memory timeout flag.
- illegal  out  1  sticky undefined-instruction flag.

Behaviour:
- Reset: async. State = RST; all outputs 0; num_inst, bus_error and illegal cleared; wait counter cleared. RST advances to IF on the first Clk edge after Reset_N rises. Reset asserted in any state, including mid-memory-wait, aborts immediately to RST.
- States: RST, IF, ID, EX, MEM, WB, HALT. All outputs are combinational from state, instr, bcond and mem_ready.
- IF: mem_req=1, iord=0, mem_we=0.
  - If mem_ready=1: ir_write=1, go to ID.
  - Otherwise stay in IF with outputs held.
- ID: decode. Transitions by class:
  - JMP (op 9): pc_write=1, pc_src=2, done.
  - JPR (op 15/funct 25): pc_write=1, pc_src=3, done.
  - JAL (op 10) and JRL (op 15/funct 26): go to WB.
  - HLT (op 15/funct 29): go to HALT, counted.
  - Undefined opcode/funct: pc_write=1, pc_src=0, illegal set, done (treated as NOP).
  - All other classes: go to EX.
- EX:
  - R-ALU (op 15/funct 0-7): alu_src_b=0, go to WB.
  - ADI/ORI/LHI (ops 4-6): alu_src_b=1, ext_zero=(op==5), go to WB.
  - LWD/SWD (ops 7, 8): alu_src_b=1, ext_zero=0, go to MEM.
  - BNE/BEQ/BGZ/BLZ (ops 0-3): pc_write=1, pc_src = bcond ? 1 : 0, done.
  - WWD (op 15/funct 28): out_write=1, pc_write=1, pc_src=0, done.
- MEM: mem_req=1, iord=1, mem_we=(op==8). While mem_ready=0, hold.
  - On mem_ready=1, LWD goes to WB.
  - On mem_ready=1, SWD completes with pc_write=1, pc_src=0.
- WB: reg_write=1, pc_write=1, then done.
  - R-ALU: reg_dst=1, wb_sel=0, pc_src=0.
  - I-ALU: reg_dst=0, wb_sel=0, pc_src=0.
  - LWD: reg_dst=0, wb_sel=1, pc_src=0.
  - JAL: reg_dst=2, wb_sel=2, pc_src=2.
  - JRL: reg_dst=2, wb_sel=2, pc_src=3.
- Done: next state is IF; num_inst increments by 1 on that same edge, wrapping modulo 2^CNT_W.
- Latency with zero-wait memory (mem_ready always 1), in cycles:
  - R/I-ALU: 4.
  - LWD: 5.
  - SWD: 4.
  - Branch and WWD: 3.
  - JAL and JRL: 3.
  - JMP and JPR: 2.
  - Each wait cycle adds 1.
- Timeout: the wait counter counts consecutive mem_ready=0 cycles in IF/MEM and clears on leaving those states. When it reaches MEM_TIMEOUT, set bus_error and go to HALT without counting.
- HALT: all strobes 0, is_halted=1. HALT is exited only by reset.
- bcond and instr are sampled only in the states listed; changes elsewhere are ignored.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants;
  - the state enum;
  - pc_src, reg_dst and wb_sel encodings;
  - an instruction-class enum (R_ALU, I_ALU, LOAD, STORE, BRANCH, JUMP, JUMP_REG, LINK, LINK_REG, WWD, HALT, ILLEGAL).
- One combinational sub-module, mc_decode: instr → class, ext_zero. It is reused by the future pipelined control.

Test Plan:
- Reset, then ADI r1 with mem_ready=1 → RST, IF, ID, EX, WB; reg_write=1 in WB only; num_inst 0→1 after 5 edges.
- LWD with mem_ready low for 3 cycles in MEM → MEM held 4 cycles with mem_req=1, iord=1, mem_we=0; wb_sel=1 in WB; total 8 cycles.
- BEQ with bcond=1, then BEQ with bcond=0 → EX pc_src=1, then 0; pc_write single-cycle pulse; 3 cycles each.
- JAL, then JRL → WB reg_dst=2, wb_sel=2, pc_src=2/3; JPR completes in 2 cycles with pc_src=3.
- MEM_TIMEOUT=4, mem_ready stuck 0 in IF → bus_error=1 and is_halted=1 after 4 wait cycles; num_inst unchanged.
- HLT → is_halted=1, num_inst+1; Reset_N pulsed mid-SWD MEM → all outputs 0 immediately, num_inst=0; opcode 11 → illegal=1, PC+1, counted.
